// File: rtl/hc_sr04_range_filter.sv
// -----------------------------------------------------------------------------
// hc_sr04_range_filter
//
// Converts HC-SR04 echo-high cycle counts into centimetres and keeps a running
// mean of the last four in-range distances.
//
// A measurement is taken when `ready` rises. An in-range raw count is rounded
// to the nearest centimetre: CYC_PER_CM/2 is added, then a restoring
// shift-subtract divider runs for 23 cycles. The result is pushed into a
// 4-entry window, and the window mean is published on the following cycle. A
// raw count above MAX_RAW gets a 1023 cm sentinel with `out_of_range` set. The
// window does not change in that case.
//
// Ports
//   clk          in   1   single 100 MHz clock
//   rst          in   1   asynchronous active-high reset
//   ready        in   1   ranging-interface idle flag, 0->1 marks a new echo
//   distanceRAW  in  22   echo-high cycle count, final when ready rises
//   dist_cm      out 10   latest converted distance (held between pulses)
//   dist_valid   out  1   one-cycle pulse marking a new dist_cm
//   out_of_range out  1   1 = current dist_cm came from a raw count > MAX_RAW
//   avg_cm       out 10   mean of the last 4 in-range distances (held)
//   avg_valid    out  1   one-cycle pulse marking a new avg_cm
//   overrun      out  1   one-cycle pulse when a capture arrives while busy
//   busy         out  1   high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module hc_sr04_range_filter #(
    parameter logic [12:0] CYC_PER_CM = 13'd5882,
    parameter logic [21:0] MAX_RAW    = 22'd2_352_800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [21:0] distanceRAW,
    output logic [9:0]  dist_cm,
    output logic        dist_valid,
    output logic        out_of_range,
    output logic [9:0]  avg_cm,
    output logic        avg_valid,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_AVERAGE = 2'd2
    } state_t;

    // The divider produces one quotient bit per step; the last step has index 22.
    localparam logic [4:0]  LAST_STEP = 5'd22;
    localparam logic [12:0] HALF_CYC  = CYC_PER_CM >> 1;
    localparam logic [9:0]  OOR_CM    = 10'd1023;
    localparam logic [2:0]  FILL_FULL = 3'd4;

    state_t      state_r;
    state_t      state_next_s;

    logic        ready_q_r;
    logic        capture_s;
    logic        in_range_s;

    // Divider state. dq_r starts out holding the dividend. Each step shifts its
    // MSB into the partial remainder and shifts the new quotient bit in at the
    // LSB, so after 23 steps dq_r holds the quotient.
    logic [22:0] dq_r;
    logic [12:0] rem_r;
    logic [4:0]  step_r;
    logic [13:0] rem_shift_s;
    logic        rem_ge_s;
    logic [12:0] rem_diff_s;
    logic [12:0] rem_next_s;
    logic [22:0] q_next_s;

    logic [9:0]  win_r [0:3];
    logic [2:0]  fill_r;
    logic [11:0] sum_s;
    logic [9:0]  avg_s;

    // Control strobes decoded from the FSM.
    logic        load_s;
    logic        step_en_s;
    logic        finish_div_s;
    logic        oor_hit_s;
    logic        avg_update_s;
    logic        overrun_hit_s;

    assign capture_s  = ready & ~ready_q_r;
    assign in_range_s = (distanceRAW <= MAX_RAW);

    // One restoring-division step. The modular 13-bit difference is exact
    // whenever it is selected, because the remainder is then below the divisor.
    assign rem_shift_s = {rem_r, dq_r[22]};
    assign rem_ge_s    = (rem_shift_s >= {1'b0, CYC_PER_CM});
    assign rem_diff_s  = rem_shift_s[12:0] - CYC_PER_CM;
    assign rem_next_s  = rem_ge_s ? rem_diff_s : rem_shift_s[12:0];
    assign q_next_s    = {dq_r[21:0], rem_ge_s};

    // Window sum. Four 10-bit entries cannot overflow 12 bits.
    assign sum_s = {2'b00, win_r[0]} + {2'b00, win_r[1]}
                 + {2'b00, win_r[2]} + {2'b00, win_r[3]};
    assign avg_s = 10'(sum_s >> 2);

    // Previous-cycle copy of ready. It resets high, so a ready line that is
    // already high after reset does not count as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q_r <= 1'b1;
        end else begin
            ready_q_r <= ready;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic. Out-of-range captures are resolved without leaving IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s && in_range_s) begin
                    state_next_s = ST_DIVIDE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (step_r == LAST_STEP) begin
                    state_next_s = ST_AVERAGE;
                end else begin
                    state_next_s = ST_DIVIDE;
                end
            end
            ST_AVERAGE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode into datapath strobes.
    always_comb begin
        load_s        = 1'b0;
        step_en_s     = 1'b0;
        finish_div_s  = 1'b0;
        oor_hit_s     = 1'b0;
        avg_update_s  = 1'b0;
        overrun_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    if (in_range_s) begin
                        load_s = 1'b1;
                    end else begin
                        oor_hit_s = 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_DIVIDE: begin
                step_en_s     = 1'b1;
                overrun_hit_s = capture_s;
                if (step_r == LAST_STEP) begin
                    finish_div_s = 1'b1;
                end else begin
                    finish_div_s = 1'b0;
                end
            end
            ST_AVERAGE: begin
                avg_update_s  = 1'b1;
                overrun_hit_s = capture_s;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Divider datapath. It loads the rounded dividend on capture and then advances one bit per DIVIDE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_r   <= 23'd0;
            rem_r  <= 13'd0;
            step_r <= 5'd0;
        end else if (load_s) begin
            dq_r   <= {1'b0, distanceRAW} + {10'd0, HALF_CYC};
            rem_r  <= 13'd0;
            step_r <= 5'd0;
        end else if (step_en_s) begin
            dq_r   <= q_next_s;
            rem_r  <= rem_next_s;
            step_r <= step_r + 5'd1;
        end else begin
            dq_r   <= dq_r;
            rem_r  <= rem_r;
            step_r <= step_r;
        end
    end

    // Averaging window. A new in-range distance enters at entry 0 and the fill count saturates at 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r[0] <= 10'd0;
            win_r[1] <= 10'd0;
            win_r[2] <= 10'd0;
            win_r[3] <= 10'd0;
            fill_r   <= 3'd0;
        end else if (finish_div_s) begin
            win_r[0] <= q_next_s[9:0];
            win_r[1] <= win_r[0];
            win_r[2] <= win_r[1];
            win_r[3] <= win_r[2];
            if (fill_r != FILL_FULL) begin
                fill_r <= fill_r + 3'd1;
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            fill_r <= fill_r;
        end
    end

    // Distance outputs. They update only on a completed divide or an out-of-range capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dist_cm      <= 10'd0;
            out_of_range <= 1'b0;
            dist_valid   <= 1'b0;
        end else begin
            dist_valid <= finish_div_s | oor_hit_s;
            if (finish_div_s) begin
                dist_cm      <= q_next_s[9:0];
                out_of_range <= 1'b0;
            end else if (oor_hit_s) begin
                dist_cm      <= OOR_CM;
                out_of_range <= 1'b1;
            end else begin
                dist_cm      <= dist_cm;
                out_of_range <= out_of_range;
            end
        end
    end

    // Average output. It is published only once the window holds four samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_cm    <= 10'd0;
            avg_valid <= 1'b0;
        end else if (avg_update_s && (fill_r == FILL_FULL)) begin
            avg_cm    <= avg_s;
            avg_valid <= 1'b1;
        end else begin
            avg_cm    <= avg_cm;
            avg_valid <= 1'b0;
        end
    end

    // Status outputs. busy follows the next state, so it matches the registered FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            busy    <= 1'b0;
        end else begin
            overrun <= overrun_hit_s;
            busy    <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_hc_sr04_range_filter.sv
// -----------------------------------------------------------------------------
// tb_hc_sr04_range_filter
//
// Directed bench for hc_sr04_range_filter. A table of raw counts with
// hand-computed distances, latencies and window averages drives the main
// checks. Hand-written sequences cover reset idle behaviour, overrun and a
// reset that arrives mid-divide.
// -----------------------------------------------------------------------------
module tb_hc_sr04_range_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [21:0] distanceRAW;
    logic [9:0]  dist_cm;
    logic        dist_valid;
    logic        out_of_range;
    logic [9:0]  avg_cm;
    logic        avg_valid;
    logic        overrun;
    logic        busy;

    hc_sr04_range_filter dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .distanceRAW  (distanceRAW),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .out_of_range (out_of_range),
        .avg_cm       (avg_cm),
        .avg_valid    (avg_valid),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic do_rst;    // reset before this vector
        int   raw;
        int   exp_cm;
        int   exp_oor;
        int   exp_lat;   // observation index of dist_valid after capture
        int   exp_avgv;  // number of avg_valid pulses expected
        int   exp_avg;   // avg_cm after the measurement
    } vec_t;

    vec_t vecs [11];

    int tests = 0;
    int fails = 0;

    // Per-measurement observations.
    int dv_k, dv_cnt, av_k, av_cnt, ov_k, ov_cnt;
    int cm_at_dv, oor_at_dv;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Create one ready rising edge with the given raw count, then watch 40
    // cycles. The loop can also inject a second rising edge or a reset pulse.
    task automatic measure(input int raw, input int ovr_at, input int rst_at);
        dv_k = 0; dv_cnt = 0; av_k = 0; av_cnt = 0; ov_k = 0; ov_cnt = 0;
        cm_at_dv = -1; oor_at_dv = -1;
        @(negedge clk);
        ready       = 1'b0;
        distanceRAW = raw[21:0];
        @(negedge clk);
        ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dist_valid) begin
                dv_cnt++;
                if (dv_k == 0) begin
                    dv_k      = k;
                    cm_at_dv  = int'(dist_cm);
                    oor_at_dv = int'(out_of_range);
                end
            end
            if (avg_valid) begin
                av_cnt++;
                if (av_k == 0) av_k = k;
            end
            if (overrun) begin
                ov_cnt++;
                if (ov_k == 0) ov_k = k;
            end
            if (ovr_at > 0 && k == ovr_at - 1) ready = 1'b0;
            if (ovr_at > 0 && k == ovr_at) ready = 1'b1;
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
            if (rst_at > 0 && k == rst_at + 2) rst = 1'b0;
        end
    endtask

    initial begin
        int pulses;
        rst         = 1'b1;
        ready       = 1'b1;
        distanceRAW = 22'd0;

        // Table: raw, cm, oor, latency, avg pulses, avg after.
        vecs[0]  = '{1'b1,  588200,  100, 0, 24, 0,   0};
        vecs[1]  = '{1'b0,    2941,    1, 0, 24, 0,   0};
        vecs[2]  = '{1'b0,    2940,    0, 0, 24, 0,   0};
        vecs[3]  = '{1'b0, 2352800,  400, 0, 24, 1, 125};
        vecs[4]  = '{1'b0, 2352801, 1023, 1,  1, 0, 125};
        vecs[5]  = '{1'b0,       0,    0, 0, 24, 1, 100};
        vecs[6]  = '{1'b1,   58820,   10, 0, 24, 0,   0};
        vecs[7]  = '{1'b0,  117640,   20, 0, 24, 0,   0};
        vecs[8]  = '{1'b0,  176460,   30, 0, 24, 0,   0};
        vecs[9]  = '{1'b0,  241162,   41, 0, 24, 1,  25};
        vecs[10] = '{1'b0,    5882,    1, 0, 24, 1,  23};

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        check("rst_dist_cm", int'(dist_cm), 0);
        check("rst_avg_cm", int'(avg_cm), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dist_valid", int'(dist_valid), 0);
        rst = 1'b0;

        // ready held high for 100 cycles after reset: no capture, no pulses.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dist_valid || avg_valid || overrun || busy) pulses++;
        end
        check("idle_pulses", pulses, 0);
        check("idle_oor", int'(out_of_range), 0);
        check("idle_dist_cm", int'(dist_cm), 0);

        // Main table.
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].do_rst) apply_reset();
            measure(vecs[v].raw, 0, 0);
            check($sformatf("v%0d_dv_lat", v), dv_k, vecs[v].exp_lat);
            check($sformatf("v%0d_dv_cnt", v), dv_cnt, 1);
            check($sformatf("v%0d_cm", v), cm_at_dv, vecs[v].exp_cm);
            check($sformatf("v%0d_oor", v), oor_at_dv, vecs[v].exp_oor);
            check($sformatf("v%0d_av_cnt", v), av_cnt, vecs[v].exp_avgv);
            if (vecs[v].exp_avgv != 0)
                check($sformatf("v%0d_av_lat", v), av_k, vecs[v].exp_lat + 1);
            check($sformatf("v%0d_avg", v), int'(avg_cm), vecs[v].exp_avg);
            check($sformatf("v%0d_cm_hold", v), int'(dist_cm), vecs[v].exp_cm);
            check($sformatf("v%0d_oor_hold", v), int'(out_of_range), vecs[v].exp_oor);
            check($sformatf("v%0d_ovr", v), ov_cnt, 0);
            check($sformatf("v%0d_busy", v), int'(busy), 0);
        end

        // Second rising edge at capture+5 is dropped with an overrun pulse.
        // The window [1,41,30,20] becomes [100,1,41,30], mean 43.
        measure(588200, 5, 0);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_lat", ov_k, 6);
        check("ovr_dv_lat", dv_k, 24);
        check("ovr_dv_cnt", dv_cnt, 1);
        check("ovr_cm", cm_at_dv, 100);
        check("ovr_av_cnt", av_cnt, 1);
        check("ovr_avg", int'(avg_cm), 43);

        // Reset at capture+10 aborts the divide and empties the window.
        measure(588200, 0, 10);
        check("abort_dv_cnt", dv_cnt, 0);
        check("abort_av_cnt", av_cnt, 0);
        check("abort_avg", int'(avg_cm), 0);
        check("abort_cm", int'(dist_cm), 0);
        check("abort_busy", int'(busy), 0);
        measure(117640, 0, 0);
        check("post_abort_cm", cm_at_dv, 20);
        check("post_abort_av_cnt", av_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish before bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hc_sr04_range_filter.md
HC_SR04_RANGE_FILTER -- requirements
Module: hc_sr04_range_filter

Interface
REQ-001 Parameter CYC_PER_CM, default 13'd5882: clk cycles per cm of range (100 MHz clock, 58.82 us per cm).
REQ-002 Parameter MAX_RAW, default 22'd2_352_800: largest in-range raw count (400 cm).
REQ-003 Port clk, input, 1: single clock (100 MHz); the block has exactly one clock.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port ready, input, 1: ranging-interface idle flag; its 0->1 transition marks a completed echo measurement.
REQ-006 Port distanceRAW, input, 22: echo-high cycle count from the ranging interface, final when ready rises.
REQ-007 Port dist_cm, output, 10: latest converted distance in cm.
REQ-008 Port dist_valid, output, 1: one-cycle pulse marking a new dist_cm.
REQ-009 Port out_of_range, output, 1: qualifies the current dist_cm; 1 = raw exceeded MAX_RAW.
REQ-010 Port avg_cm, output, 10: mean of the last 4 in-range distances.
REQ-011 Port avg_valid, output, 1: one-cycle pulse marking a new avg_cm.
REQ-012 Port overrun, output, 1: one-cycle pulse when a measurement is dropped.
REQ-013 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-014 Edge detect: ready_q SHALL register ready each cycle, with reset value 1; capture = ready & ~ready_q.
REQ-015 FSM states: IDLE, DIVIDE, AVERAGE.
REQ-016 IDLE + capture + distanceRAW <= MAX_RAW: latch dividend = distanceRAW + CYC_PER_CM/2 (23-bit, round-to-nearest) and go to DIVIDE.
REQ-017 IDLE + capture + distanceRAW > MAX_RAW: on the next edge set dist_cm=10'd1023, out_of_range=1, and pulse dist_valid; stay in IDLE; leave the window untouched.
REQ-018 DIVIDE: restoring shift-subtract divide by CYC_PER_CM, one quotient bit per cycle, exactly 23 cycles, then go to AVERAGE.
REQ-019 On the DIVIDE->AVERAGE edge: dist_cm = quotient[9:0] (<=400 by construction), out_of_range=0, dist_valid pulses, and the sample is pushed into the 4-entry window.
REQ-020 AVERAGE (one cycle): recompute the 12-bit window sum; avg_cm = sum>>2 (truncate); return to IDLE.
REQ-021 avg_valid pulses on the AVERAGE->IDLE edge only when fill count >= 4; fill count saturates at 4.
REQ-022 Latency: an in-range sample gives dist_valid 24 cycles after the capture edge and avg_valid 1 cycle later; an out-of-range sample gives dist_valid 1 cycle after capture.
REQ-023 A capture while busy=1 SHALL pulse overrun for 1 cycle and be discarded; the in-flight computation is unaffected.
REQ-024 dist_cm, out_of_range and avg_cm SHALL hold their values between pulses.
REQ-025 distanceRAW=0 is a valid sample: dist_cm=0, pushed into the window.
REQ-026 distanceRAW == MAX_RAW is in range: dist_cm=400.

Reset
REQ-027 rst SHALL asynchronously force: FSM=IDLE, ready_q=1, all window entries and fill count=0, and dist_cm, avg_cm, out_of_range, dist_valid, avg_valid, overrun, busy all 0.
REQ-028 rst asserted mid-DIVIDE SHALL abort the computation: no dist_valid follows, and the window is cleared.
REQ-029 After rst releases with ready=1, no capture occurs until ready has gone low and then high again.

Verification
REQ-030 Reset with ready held 1 for 100 cycles -> all outputs 0; no dist_valid, avg_valid or overrun pulses.
REQ-031 ready 0->1 with distanceRAW=588200 -> dist_cm=100, out_of_range=0, dist_valid at capture+24; no avg_valid (fill=1).
REQ-032 Rounding boundary: raw=2941 -> dist_cm=1; raw=2940 -> dist_cm=0; raw=2352800 -> dist_cm=400.
REQ-033 raw=2352801 -> dist_cm=1023, out_of_range=1, dist_valid at capture+1; window and fill count unchanged.
REQ-034 Four in-range samples of 10, 20, 30, 41 cm -> avg_valid only after the 4th, with avg_cm=25; a 5th sample of 1 cm -> avg_cm=23.
REQ-035 Second ready rise at capture+5 -> overrun pulse, and the first result still completes correctly; separately, rst at capture+10 -> no dist_valid and avg window emptied.
